// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: holds the PC, drives the TLB lookup, issues one-outstanding
// SRAM-like instruction requests and hands instructions or fetch exceptions to decode.
module inst_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_vaddr,
    input  logic [31:0] tlb_paddr,
    input  logic [1:0]  tlb_ex,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic [31:0] inst_rdata,
    input  logic        inst_data_ok,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        ds_allowin,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst,
    output logic        fs_ex,
    output logic [4:0]  fs_excode,
    output logic        fs_tlb_refill,
    output logic [31:0] fs_badvaddr
);

    localparam logic [2:0] S_REQ   = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_HOLD  = 3'd2;
    localparam logic [2:0] S_EXC   = 3'd3;
    localparam logic [2:0] S_XWAIT = 3'd4;

    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_TLBL = 5'h02;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        cancel_q, cancel_d;
    logic [31:0] inst_q, inst_d;
    logic        ex_q, ex_d;
    logic [4:0]  excode_q, excode_d;
    logic        refill_q, refill_d;
    logic [31:0] badvaddr_q, badvaddr_d;

    logic        adel;
    logic        tlbl_refill;
    logic        tlbl_invalid;
    logic        fetch_ex;
    logic [4:0]  fetch_excode;
    logic        fetch_refill;

    // Misalignment outranks any TLB fault; a "modified" code is harmless for a read.
    assign adel         = (pc_q[1:0] != 2'b00);
    assign tlbl_refill  = (tlb_ex == 2'd1);
    assign tlbl_invalid = (tlb_ex == 2'd2);
    assign fetch_ex     = adel | tlbl_refill | tlbl_invalid;
    assign fetch_excode = adel ? EXC_ADEL : EXC_TLBL;
    assign fetch_refill = ~adel & tlbl_refill;

    assign pc_vaddr       = pc_q;
    assign inst_addr      = tlb_paddr;
    assign inst_req       = (state_q == S_REQ) & ~fetch_ex;
    assign fs_to_ds_valid = ((state_q == S_HOLD) | (state_q == S_EXC)) & ~redirect_valid;
    assign fs_pc          = pc_q;
    assign fs_inst        = inst_q;
    assign fs_ex          = ex_q;
    assign fs_excode      = excode_q;
    assign fs_tlb_refill  = refill_q;
    assign fs_badvaddr    = badvaddr_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cancel_d   = cancel_q;
        inst_d     = inst_q;
        ex_d       = ex_q;
        excode_d   = excode_q;
        refill_d   = refill_q;
        badvaddr_d = badvaddr_q;

        if (redirect_valid) begin
            pc_d = redirect_pc;
            case (state_q)
                S_REQ: begin
                    // An already-accepted request must still drain its data beat.
                    if (inst_req && inst_addr_ok) begin
                        state_d  = S_WAIT;
                        cancel_d = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        state_d  = S_REQ;
                        cancel_d = 1'b0;
                    end else begin
                        cancel_d = 1'b1;
                    end
                end
                default: begin
                    state_d    = S_REQ;
                    inst_d     = 32'h0;
                    ex_d       = 1'b0;
                    excode_d   = 5'h0;
                    refill_d   = 1'b0;
                    badvaddr_d = 32'h0;
                end
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (fetch_ex) begin
                        state_d    = S_EXC;
                        inst_d     = 32'h0;
                        ex_d       = 1'b1;
                        excode_d   = fetch_excode;
                        refill_d   = fetch_refill;
                        badvaddr_d = pc_q;
                    end else if (inst_addr_ok) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        if (cancel_q) begin
                            cancel_d = 1'b0;
                            state_d  = S_REQ;
                        end else begin
                            state_d    = S_HOLD;
                            inst_d     = inst_rdata;
                            ex_d       = 1'b0;
                            excode_d   = 5'h0;
                            refill_d   = 1'b0;
                            badvaddr_d = 32'h0;
                        end
                    end
                end
                S_HOLD: begin
                    if (ds_allowin) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = S_REQ;
                    end
                end
                S_EXC: begin
                    if (ds_allowin) begin
                        state_d = S_XWAIT;
                    end
                end
                S_XWAIT: begin
                    state_d = S_XWAIT;
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            cancel_q   <= 1'b0;
            inst_q     <= 32'h0;
            ex_q       <= 1'b0;
            excode_q   <= 5'h0;
            refill_q   <= 1'b0;
            badvaddr_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cancel_q   <= cancel_d;
            inst_q     <= inst_d;
            ex_q       <= ex_d;
            excode_q   <= excode_d;
            refill_q   <= refill_d;
            badvaddr_q <= badvaddr_d;
        end
    end

endmodule
